dma_controller_xfer: RTL and testbench

DMA_CONTROLLER_XFER -- requirements
Module: dma_controller_xfer

---
 rtl/dma_controller_xfer_pkg.sv | 27 ++
 rtl/dma_controller_xfer_ctx.sv | 66 ++++++
 rtl/dma_controller_xfer.sv | 144 ++++++++++++++
 tb/tb_dma_controller_xfer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_controller_xfer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_controller_pkg
// Description : Shared types for the DMA transfer engine: FSM state encoding
//               and the per-channel context record (src, dst, remaining).
// Revision    : 1.0 - initial release
// ============================================================================
package dma_controller_pkg;

    localparam int unsigned DMA_ADDR_W = 32;
    localparam int unsigned DMA_CNT_W  = 16;

    typedef enum logic [1:0] {
        XFER_IDLE = 2'd0,
        XFER_RD   = 2'd1,
        XFER_WR   = 2'd2,
        XFER_UPD  = 2'd3
    } xfer_state_e;

    typedef struct packed {
        logic [DMA_ADDR_W-1:0] src;
        logic [DMA_ADDR_W-1:0] dst;
        logic [DMA_CNT_W-1:0]  remaining;
    } chan_ctx_t;

endpackage
`default_nettype wire

// File: rtl/dma_controller_xfer_ctx.sv
`default_nettype none
// ============================================================================
// Module      : dma_controller_xfer_ctx
// Description : Per-channel context register file. A load pulse copies the
//               channel configuration; an update advances the active channel.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_controller_xfer_ctx
    import dma_controller_pkg::*;
#(
    parameter int CHANNELS_AMOUNT = 4,
    parameter int CHANNEL_CNT_W   = $clog2(CHANNELS_AMOUNT),
    parameter int DATA_W          = 32
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [CHANNELS_AMOUNT-1:0]                 ld_i,
    input  logic [CHANNELS_AMOUNT-1:0][DMA_ADDR_W-1:0] cfg_src_addr_i,
    input  logic [CHANNELS_AMOUNT-1:0][DMA_ADDR_W-1:0] cfg_dst_addr_i,
    input  logic [CHANNELS_AMOUNT-1:0][DMA_CNT_W-1:0]  cfg_cnt_i,
    input  logic [CHANNELS_AMOUNT-1:0]                 cfg_src_inc_i,
    input  logic [CHANNELS_AMOUNT-1:0]                 cfg_dst_inc_i,
    input  logic [CHANNELS_AMOUNT-1:0]                 circ_i,
    input  logic                                       upd_i,
    input  logic [CHANNEL_CNT_W-1:0]                   upd_ch_i,
    output chan_ctx_t                                  ctx_o [CHANNELS_AMOUNT]
);

    localparam logic [DMA_ADDR_W-1:0] ADDR_STEP = DMA_ADDR_W'(DATA_W / 8);
    localparam logic [DMA_CNT_W-1:0]  CNT_ONE   = DMA_CNT_W'(1);

    for (genvar i = 0; i < CHANNELS_AMOUNT; i++) begin : g_chan
        chan_ctx_t ctx_q;
        chan_ctx_t cfg_ctx;
        logic      hit;

        assign hit     = upd_i && (upd_ch_i == CHANNEL_CNT_W'(i));
        assign cfg_ctx = '{src: cfg_src_addr_i[i], dst: cfg_dst_addr_i[i], remaining: cfg_cnt_i[i]};
        assign ctx_o[i] = ctx_q;

        // A load on the same cycle as this channel's update takes priority.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                ctx_q <= '0;
            end else if (ld_i[i]) begin
                ctx_q <= cfg_ctx;
            end else if (hit) begin
                if ((ctx_q.remaining == CNT_ONE) && circ_i[i]) begin
                    ctx_q <= cfg_ctx;
                end else begin
                    if (ctx_q.remaining != '0) begin
                        ctx_q.remaining <= ctx_q.remaining - CNT_ONE;
                    end
                    if (cfg_src_inc_i[i]) begin
                        ctx_q.src <= ctx_q.src + ADDR_STEP;
                    end
                    if (cfg_dst_inc_i[i]) begin
                        ctx_q.dst <= ctx_q.dst + ADDR_STEP;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_controller_xfer.sv
`default_nettype none
// ============================================================================
// Module      : dma_controller_xfer
// Description : Single-beat-per-grant DMA transfer engine (read, write, update).
//               Circular reload is compiled in with DMA_CONTROLLER_XFER_CIRC_EN.
//               Context widths follow DMA_ADDR_W / DMA_CNT_W of the package.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_controller_xfer
    import dma_controller_pkg::*;
#(
    parameter int CHANNELS_AMOUNT = 4,
    parameter int CHANNEL_CNT_W   = $clog2(CHANNELS_AMOUNT),
    parameter int ADDR_W          = DMA_ADDR_W,
    parameter int DATA_W          = 32,
    parameter int CNT_W           = DMA_CNT_W
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   req_valid_i,
    input  logic [CHANNEL_CNT_W-1:0]               req_num_i,
    output logic                                   ready_o,
    input  logic [CHANNELS_AMOUNT-1:0]             ld_i,
    input  logic [CHANNELS_AMOUNT-1:0][ADDR_W-1:0] cfg_src_addr_i,
    input  logic [CHANNELS_AMOUNT-1:0][ADDR_W-1:0] cfg_dst_addr_i,
    input  logic [CHANNELS_AMOUNT-1:0][CNT_W-1:0]  cfg_cnt_i,
    input  logic [CHANNELS_AMOUNT-1:0]             cfg_src_inc_i,
    input  logic [CHANNELS_AMOUNT-1:0]             cfg_dst_inc_i,
    input  logic [CHANNELS_AMOUNT-1:0]             cfg_circ_i,
    input  logic [CHANNELS_AMOUNT-1:0]             cfg_en_i,
    output logic                                   rd_req_o,
    output logic [ADDR_W-1:0]                      rd_addr_o,
    input  logic                                   rd_ack_i,
    input  logic [DATA_W-1:0]                      rd_data_i,
    output logic                                   wr_req_o,
    output logic [ADDR_W-1:0]                      wr_addr_o,
    output logic [DATA_W-1:0]                      wr_data_o,
    input  logic                                   wr_ack_i,
    output logic [CHANNELS_AMOUNT-1:0]             tc_o,
    output logic [CHANNELS_AMOUNT-1:0]             err_o,
    output logic                                   busy_o
);

    localparam logic [1:0] ST_IDLE = XFER_IDLE;
    localparam logic [1:0] ST_RD   = XFER_RD;
    localparam logic [1:0] ST_WR   = XFER_WR;
    localparam logic [1:0] ST_UPD  = XFER_UPD;

    logic [1:0]                 state;
    logic [CHANNEL_CNT_W-1:0]   cur_ch;
    logic [DATA_W-1:0]          data_q;
    logic [CHANNELS_AMOUNT-1:0] tc_q;
    logic [CHANNELS_AMOUNT-1:0] err_q;
    logic [CHANNELS_AMOUNT-1:0] circ;
    chan_ctx_t                  ctx [CHANNELS_AMOUNT];
    chan_ctx_t                  cur_ctx;
    logic                       grant_ok;

`ifdef DMA_CONTROLLER_XFER_CIRC_EN
    assign circ = cfg_circ_i;
`else
    logic unused_circ;
    assign circ        = '0;
    assign unused_circ = ^cfg_circ_i;
`endif

    dma_controller_xfer_ctx #(
        .CHANNELS_AMOUNT (CHANNELS_AMOUNT),
        .CHANNEL_CNT_W   (CHANNEL_CNT_W),
        .DATA_W          (DATA_W)
    ) u_ctx (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ld_i           (ld_i),
        .cfg_src_addr_i (cfg_src_addr_i),
        .cfg_dst_addr_i (cfg_dst_addr_i),
        .cfg_cnt_i      (cfg_cnt_i),
        .cfg_src_inc_i  (cfg_src_inc_i),
        .cfg_dst_inc_i  (cfg_dst_inc_i),
        .circ_i         (circ),
        .upd_i          (state == ST_UPD),
        .upd_ch_i       (cur_ch),
        .ctx_o          (ctx)
    );

    assign cur_ctx  = ctx[cur_ch];
    assign grant_ok = cfg_en_i[req_num_i] && (ctx[req_num_i].remaining != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            cur_ch <= '0;
            data_q <= '0;
            tc_q   <= '0;
            err_q  <= '0;
        end else begin
            tc_q  <= '0;
            err_q <= '0;
            case (state)
                ST_IDLE: begin
                    // A grant that cannot be serviced is consumed and flagged.
                    if (req_valid_i) begin
                        if (grant_ok) begin
                            cur_ch <= req_num_i;
                            state  <= ST_RD;
                        end else begin
                            err_q <= CHANNELS_AMOUNT'(1) << req_num_i;
                        end
                    end
                end
                ST_RD: begin
                    if (rd_ack_i) begin
                        data_q <= rd_data_i;
                        state  <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (wr_ack_i) begin
                        state <= ST_UPD;
                    end
                end
                ST_UPD: begin
                    state <= ST_IDLE;
                    if (cur_ctx.remaining == DMA_CNT_W'(1)) begin
                        tc_q <= CHANNELS_AMOUNT'(1) << cur_ch;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ready_o   = (state == ST_IDLE);
    assign busy_o    = !ready_o;
    assign rd_req_o  = (state == ST_RD);
    assign wr_req_o  = (state == ST_WR);
    assign rd_addr_o = cur_ctx.src;
    assign wr_addr_o = cur_ctx.dst;
    assign wr_data_o = data_q;
    assign tc_o      = tc_q;
    assign err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_controller_xfer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_controller_xfer
// Description : Self-checking bench: directed vector table, hand sequences for
//               reset/circular/enable-drop, and a randomized model-checked run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_controller_xfer;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic [1:0]       req_num = '0;
    logic             ready, busy;
    logic [3:0]       ld = '0;
    logic [3:0][31:0] cfg_src = '0;
    logic [3:0][31:0] cfg_dst = '0;
    logic [3:0][15:0] cfg_cnt = '0;
    logic [3:0]       cfg_sinc = '0, cfg_dinc = '0, cfg_circ = '0, cfg_en = '0;
    logic             rd_req, wr_req;
    logic             rd_ack = 1'b0, wr_ack = 1'b0;
    logic [31:0]      rd_addr, wr_addr, wr_data;
    logic [31:0]      rd_data = '0;
    logic [3:0]       tc, err;

    always #5 clk = ~clk;

    dma_controller_xfer dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_num_i(req_num), .ready_o(ready),
        .ld_i(ld), .cfg_src_addr_i(cfg_src), .cfg_dst_addr_i(cfg_dst), .cfg_cnt_i(cfg_cnt),
        .cfg_src_inc_i(cfg_sinc), .cfg_dst_inc_i(cfg_dinc), .cfg_circ_i(cfg_circ), .cfg_en_i(cfg_en),
        .rd_req_o(rd_req), .rd_addr_o(rd_addr), .rd_ack_i(rd_ack), .rd_data_i(rd_data),
        .wr_req_o(wr_req), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_ack_i(wr_ack),
        .tc_o(tc), .err_o(err), .busy_o(busy)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: per-channel state as plain arrays.
    logic [31:0] m_src [4], m_dst [4], m_cfg_src [4], m_cfg_dst [4];
    int          m_rem [4], m_cfg_cnt [4];
    bit          m_sinc [4], m_dinc [4], m_circ [4], m_en [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int ch, input logic [31:0] s, input logic [31:0] d, input int cnt,
                        input bit si, input bit di, input bit ci, input bit en);
        cfg_src[ch] = s; cfg_dst[ch] = d; cfg_cnt[ch] = 16'(cnt);
        cfg_sinc[ch] = si; cfg_dinc[ch] = di; cfg_circ[ch] = ci; cfg_en[ch] = en;
        ld = 4'b0001 << ch;
        tick();
        ld = '0;
        m_src[ch] = s; m_dst[ch] = d; m_rem[ch] = cnt;
        m_cfg_src[ch] = s; m_cfg_dst[ch] = d; m_cfg_cnt[ch] = cnt;
        m_sinc[ch] = si; m_dinc[ch] = di; m_circ[ch] = ci; m_en[ch] = en;
    endtask

    task automatic beat(input string tag, input int ch, input int rdd, input int wrd,
                        input logic [31:0] data, input bit ok, input logic [31:0] ea,
                        input logic [31:0] eb, input bit etc, input bit drop_en);
        logic [3:0] onehot;
        onehot = 4'b0001 << ch;
        req_valid = 1'b1; req_num = 2'(ch);
        tick();
        req_valid = 1'b0; req_num = 2'($urandom);
        if (!ok) begin
            chk({tag, "_err"}, 32'(err), 32'(onehot));
            chk({tag, "_noreq"}, 32'({rd_req, wr_req}), 32'd0);
            chk({tag, "_ready"}, 32'(ready), 32'd1);
            tick();
            chk({tag, "_err_clr"}, 32'(err), 32'd0);
            return;
        end
        if (drop_en) cfg_en[ch] = 1'b0;
        chk({tag, "_rdreq"}, 32'({rd_req, wr_req, ready, busy}), 32'b1001);
        chk({tag, "_rdaddr"}, rd_addr, ea);
        for (int i = 0; i < rdd; i++) begin
            tick();
            chk({tag, "_rdhold"}, 32'(rd_req && !ready && (rd_addr == ea)), 32'd1);
        end
        rd_ack = 1'b1; rd_data = data;
        tick();
        rd_ack = 1'b0; rd_data = $urandom;
        chk({tag, "_wrreq"}, 32'({rd_req, wr_req}), 32'd1);
        chk({tag, "_wraddr"}, wr_addr, eb);
        chk({tag, "_wrdata"}, wr_data, data);
        for (int i = 0; i < wrd; i++) begin
            tick();
            chk({tag, "_wrhold"}, 32'(wr_req && (wr_addr == eb) && (wr_data == data)), 32'd1);
        end
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        chk({tag, "_upd"}, 32'({ready, rd_req, wr_req}), 32'd0);
        tick();
        chk({tag, "_idle"}, 32'(ready), 32'd1);
        chk({tag, "_tc"}, 32'(tc), etc ? 32'(onehot) : 32'd0);
        tick();
        chk({tag, "_tc_clr"}, 32'(tc), 32'd0);
    endtask

    typedef struct {
        int          op;     // 0 = load channel, 1 = grant one beat
        int          ch;
        logic [31:0] a;      // load: src        beat: expected read address
        logic [31:0] b;      // load: dst        beat: expected write address
        int          cnt;
        bit          sinc, dinc, en;
        int          rdd, wrd;
        bit          ok, tc;
    } vec_t;

    vec_t tbl [13];

    int          r_ch, r_rdd, r_wrd;
    bit          r_ok, r_tc;
    logic [31:0] r_data;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{op:0, ch:0, a:32'h100, b:32'h200, cnt:2, sinc:1, dinc:1, en:1, rdd:0, wrd:0, ok:0, tc:0};
        tbl[1]  = '{op:1, ch:0, a:32'h100, b:32'h200, cnt:0, sinc:0, dinc:0, en:0, rdd:0, wrd:0, ok:1, tc:0};
        tbl[2]  = '{op:1, ch:0, a:32'h104, b:32'h204, cnt:0, sinc:0, dinc:0, en:0, rdd:0, wrd:0, ok:1, tc:1};
        tbl[3]  = '{op:1, ch:0, a:32'h0,   b:32'h0,   cnt:0, sinc:0, dinc:0, en:0, rdd:0, wrd:0, ok:0, tc:0};
        tbl[4]  = '{op:0, ch:1, a:32'h300, b:32'h400, cnt:3, sinc:1, dinc:1, en:0, rdd:0, wrd:0, ok:0, tc:0};
        tbl[5]  = '{op:1, ch:1, a:32'h0,   b:32'h0,   cnt:0, sinc:0, dinc:0, en:0, rdd:0, wrd:0, ok:0, tc:0};
        tbl[6]  = '{op:0, ch:2, a:32'h40,  b:32'h80,  cnt:2, sinc:1, dinc:0, en:1, rdd:0, wrd:0, ok:0, tc:0};
        tbl[7]  = '{op:1, ch:2, a:32'h40,  b:32'h80,  cnt:0, sinc:0, dinc:0, en:0, rdd:1, wrd:3, ok:1, tc:0};
        tbl[8]  = '{op:1, ch:2, a:32'h44,  b:32'h80,  cnt:0, sinc:0, dinc:0, en:0, rdd:0, wrd:1, ok:1, tc:1};
        tbl[9]  = '{op:0, ch:3, a:32'hFFFF_FFFC, b:32'h500, cnt:2, sinc:1, dinc:1, en:1, rdd:0, wrd:0, ok:0, tc:0};
        tbl[10] = '{op:1, ch:3, a:32'hFFFF_FFFC, b:32'h500, cnt:0, sinc:0, dinc:0, en:0, rdd:5, wrd:0, ok:1, tc:0};
        tbl[11] = '{op:1, ch:3, a:32'h0,   b:32'h504, cnt:0, sinc:0, dinc:0, en:0, rdd:0, wrd:0, ok:1, tc:1};
        tbl[12] = '{op:1, ch:3, a:32'h0,   b:32'h0,   cnt:0, sinc:0, dinc:0, en:0, rdd:0, wrd:0, ok:0, tc:0};

        // Reset values
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_ready_busy", 32'({ready, busy}), 32'b10);
        chk("rst_reqs", 32'({rd_req, wr_req}), 32'd0);
        chk("rst_pulses", 32'({tc, err}), 32'd0);
        chk("rst_rdaddr", rd_addr, 32'd0);
        chk("rst_wraddr", wr_addr, 32'd0);
        chk("rst_wrdata", wr_data, 32'd0);

        // Directed vector table
        for (int v = 0; v < 13; v++) begin
            if (tbl[v].op == 0)
                load(tbl[v].ch, tbl[v].a, tbl[v].b, tbl[v].cnt, tbl[v].sinc, tbl[v].dinc, 1'b0, tbl[v].en);
            else
                beat($sformatf("v%0d", v), tbl[v].ch, tbl[v].rdd, tbl[v].wrd, $urandom,
                     tbl[v].ok, tbl[v].a, tbl[v].b, tbl[v].tc, 1'b0);
        end

        // Stray acks in IDLE are ignored
        rd_ack = 1'b1; wr_ack = 1'b1;
        tick();
        rd_ack = 1'b0; wr_ack = 1'b0;
        chk("stray_ack", 32'({ready, rd_req, wr_req}), 32'b100);

        // Enable dropped mid-beat: beat completes, later grant errors
        load(1, 32'h600, 32'h700, 2, 1'b1, 1'b1, 1'b0, 1'b1);
        beat("drop", 1, 1, 0, 32'h1234_5678, 1'b1, 32'h600, 32'h700, 1'b0, 1'b1);
        beat("drop_after", 1, 0, 0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Circular reload
        load(2, 32'h10, 32'h20, 1, 1'b1, 1'b1, 1'b1, 1'b1);
        beat("circ1", 2, 0, 0, 32'hAAAA_0001, 1'b1, 32'h10, 32'h20, 1'b1, 1'b0);
`ifdef DMA_CONTROLLER_XFER_CIRC_EN
        beat("circ2", 2, 0, 0, 32'hAAAA_0002, 1'b1, 32'h10, 32'h20, 1'b1, 1'b0);
`else
        beat("circ2", 2, 0, 0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
`endif

        // Asynchronous reset while a write is pending
        load(0, 32'h1000, 32'h2000, 3, 1'b1, 1'b1, 1'b0, 1'b1);
        req_valid = 1'b1; req_num = 2'd0;
        tick();
        req_valid = 1'b0;
        rd_ack = 1'b1; rd_data = 32'hCAFE_0001;
        tick();
        rd_ack = 1'b0;
        chk("prerst_wrreq", 32'(wr_req), 32'd1);
        chk("prerst_wraddr", wr_addr, 32'h2000);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_wrreq", 32'({rd_req, wr_req}), 32'd0);
        chk("async_rst_ready", 32'(ready), 32'd1);
        chk("async_rst_data", wr_data, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("postrst_ready", 32'(ready), 32'd1);
        beat("postrst_g", 0, 0, 0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Randomized run against the reference model
        rst = 1'b1; tick(); rst = 1'b0; tick();
        cfg_en = '0; cfg_circ = '0;
        for (int c = 0; c < 4; c++) begin
            m_src[c] = '0; m_dst[c] = '0; m_rem[c] = 0; m_en[c] = 1'b0;
            m_sinc[c] = 1'b0; m_dinc[c] = 1'b0; m_circ[c] = 1'b0;
            m_cfg_src[c] = '0; m_cfg_dst[c] = '0; m_cfg_cnt[c] = 0;
        end
        for (int it = 0; it < 80; it++) begin
            r_ch = $urandom_range(3);
            if ($urandom_range(3) == 0) begin
                load(r_ch, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, $urandom_range(3),
                     1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(4) != 0));
            end else begin
                r_ok   = m_en[r_ch] && (m_rem[r_ch] != 0);
                r_tc   = r_ok && (m_rem[r_ch] == 1);
                r_rdd  = $urandom_range(3);
                r_wrd  = $urandom_range(3);
                r_data = $urandom;
                beat($sformatf("r%0d", it), r_ch, r_rdd, r_wrd, r_data, r_ok,
                     m_src[r_ch], m_dst[r_ch], r_tc, 1'b0);
                if (r_ok) begin
                    m_rem[r_ch] = m_rem[r_ch] - 1;
                    if (m_sinc[r_ch]) m_src[r_ch] = m_src[r_ch] + 32'd4;
                    if (m_dinc[r_ch]) m_dst[r_ch] = m_dst[r_ch] + 32'd4;
`ifdef DMA_CONTROLLER_XFER_CIRC_EN
                    if (m_rem[r_ch] == 0 && m_circ[r_ch]) begin
                        m_src[r_ch] = m_cfg_src[r_ch];
                        m_dst[r_ch] = m_cfg_dst[r_ch];
                        m_rem[r_ch] = m_cfg_cnt[r_ch];
                    end
`endif
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
